// File: rtl/posicionador_embarcacao.sv
// Ship-placement engine for one Batalha Naval vessel: turns player pulses into the
// packed cell-coordinate vector read by the VGA renderers, with bounds and overlap checks.
module posicionador_embarcacao #(
  parameter int TAMANHO = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        habilitar,
  input  logic        btn_cima,
  input  logic        btn_baixo,
  input  logic        btn_esq,
  input  logic        btn_dir,
  input  logic        btn_girar,
  input  logic        btn_confirmar,
  input  logic [63:0] mapaOcupado,
  output logic [63:0] posicoesEmbarcacao,
  output logic        posicionada,
  output logic        erro,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    POSICIONANDO = 2'd1,
    VALIDANDO    = 2'd2,
    FIXADO       = 2'd3
  } estado_t;

  estado_t     estadoReg, estadoNext;
  logic [3:0]  xReg, xNext, yReg, yNext;
  logic        verticalReg, verticalNext;
  logic        erroReg, erroNext;
  logic [63:0] vetorReg, vetorNext;
  logic [4:0]  colisaoCel;
  logic        colisao;

  // True when every cell of a ship anchored at (x,y) stays inside the 8x8 board.
  function automatic logic cabe(input int x, input int y, input logic vert);
    int xFim;
    int yFim;
    xFim = vert ? x : x + TAMANHO - 1;
    yFim = vert ? y + TAMANHO - 1 : y;
    return (x >= 1) && (y >= 1) && (xFim <= 8) && (yFim <= 8);
  endfunction

  // Per-cell coordinates: current anchor feeds the overlap check, next anchor feeds the vector.
  assign vetorNext[2:0]   = 3'b000;
  assign vetorNext[63:43] = '0;

  for (genvar gi = 0; gi < 5; gi++) begin : gCel
    if (gi < TAMANHO) begin : gUsada
      logic [3:0] xAtual, yAtual, xProx, yProx;
      logic [5:0] idxMapa;
      assign xAtual  = verticalReg  ? xReg  : xReg  + 4'(gi);
      assign yAtual  = verticalReg  ? yReg  + 4'(gi) : yReg;
      assign xProx   = verticalNext ? xNext : xNext + 4'(gi);
      assign yProx   = verticalNext ? yNext + 4'(gi) : yNext;
      assign idxMapa = {3'(yAtual - 4'd1), 3'(xAtual - 4'd1)};
      assign colisaoCel[gi] = mapaOcupado[idxMapa];
      assign vetorNext[6+8*gi -: 4]  = xProx;
      assign vetorNext[10+8*gi -: 4] = 4'd9 - yProx;
    end else begin : gLivre
      assign colisaoCel[gi] = 1'b0;
      assign vetorNext[10+8*gi -: 8] = '0;
    end
  end

  assign colisao = |colisaoCel;

  always_comb begin
    int xi;
    int yi;
    estadoNext   = estadoReg;
    xNext        = xReg;
    yNext        = yReg;
    verticalNext = verticalReg;
    erroNext     = 1'b0;
    xi           = int'(xReg);
    yi           = int'(yReg);
    unique case (estadoReg)
      OCIOSO: begin
        if (habilitar) begin
          estadoNext   = POSICIONANDO;
          xNext        = 4'd1;
          yNext        = 4'd1;
          verticalNext = 1'b0;
        end
      end
      POSICIONANDO: begin
        // Single command per cycle; lower-priority pulses are simply dropped.
        if (habilitar) begin
          xNext        = 4'd1;
          yNext        = 4'd1;
          verticalNext = 1'b0;
        end else if (btn_confirmar) begin
          estadoNext = VALIDANDO;
        end else if (btn_girar) begin
          if (cabe(xi, yi, ~verticalReg)) verticalNext = ~verticalReg;
        end else if (btn_cima) begin
          if (cabe(xi, yi + 1, verticalReg)) yNext = yReg + 4'd1;
        end else if (btn_baixo) begin
          if (cabe(xi, yi - 1, verticalReg)) yNext = yReg - 4'd1;
        end else if (btn_esq) begin
          if (cabe(xi - 1, yi, verticalReg)) xNext = xReg - 4'd1;
        end else if (btn_dir) begin
          if (cabe(xi + 1, yi, verticalReg)) xNext = xReg + 4'd1;
        end
      end
      VALIDANDO: begin
        if (habilitar) begin
          estadoNext   = POSICIONANDO;
          xNext        = 4'd1;
          yNext        = 4'd1;
          verticalNext = 1'b0;
        end else if (colisao) begin
          estadoNext = POSICIONANDO;
          erroNext   = 1'b1;
        end else begin
          estadoNext = FIXADO;
        end
      end
      FIXADO: begin
        if (habilitar) begin
          estadoNext   = POSICIONANDO;
          xNext        = 4'd1;
          yNext        = 4'd1;
          verticalNext = 1'b0;
        end
      end
      default: estadoNext = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estadoReg   <= OCIOSO;
      xReg        <= 4'd1;
      yReg        <= 4'd1;
      verticalReg <= 1'b0;
      erroReg     <= 1'b0;
      vetorReg    <= '0;
    end else begin
      estadoReg   <= estadoNext;
      xReg        <= xNext;
      yReg        <= yNext;
      verticalReg <= verticalNext;
      erroReg     <= erroNext;
      vetorReg    <= (estadoNext == OCIOSO) ? '0 : vetorNext;
    end
  end

  assign posicoesEmbarcacao = vetorReg;
  assign erro               = erroReg;
  assign posicionada        = (estadoReg == FIXADO);
  assign ocupado            = (estadoReg == POSICIONANDO) || (estadoReg == VALIDANDO);

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Randomized bench for posicionador_embarcacao with an abstract board model and
// a few hand-computed vectors that pin the model.
module tb_posicionador_embarcacao;

  localparam int T = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        habilitar = 1'b0, btn_cima = 1'b0, btn_baixo = 1'b0, btn_esq = 1'b0;
  logic        btn_dir = 1'b0, btn_girar = 1'b0, btn_confirmar = 1'b0;
  logic [63:0] mapaOcupado = '0;
  logic [63:0] posicoesEmbarcacao;
  logic        posicionada, erro, ocupado;

  posicionador_embarcacao #(.TAMANHO(T)) dut (
    .clk(clk), .reset(reset), .habilitar(habilitar),
    .btn_cima(btn_cima), .btn_baixo(btn_baixo), .btn_esq(btn_esq), .btn_dir(btn_dir),
    .btn_girar(btn_girar), .btn_confirmar(btn_confirmar), .mapaOcupado(mapaOcupado),
    .posicoesEmbarcacao(posicoesEmbarcacao), .posicionada(posicionada),
    .erro(erro), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Model: phase 0=idle 1=placing 2=validating 3=fixed; anchor (mx,my), orientation mv.
  int          mSt = 0, mx = 1, my = 1;
  logic        mv = 1'b0, mErr = 1'b0;
  int          nTests = 0, nFail = 0;
  logic        pinOn = 1'b0;
  logic [66:0] pinVal = '0;
  string       pinName = "";

  function automatic logic fits(input int x, input int y, input logic v);
    for (int i = 0; i < T; i++) begin
      int cx, cy;
      cx = v ? x : x + i;
      cy = v ? y + i : y;
      if (cx < 1 || cx > 8 || cy < 1 || cy > 8) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic collides(input int x, input int y, input logic v, input logic [63:0] m);
    for (int i = 0; i < T; i++) begin
      int cx, cy;
      cx = v ? x : x + i;
      cy = v ? y + i : y;
      if (m[8*(cy-1) + (cx-1)]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] shipVec(input int st, input int x, input int y, input logic v);
    logic [63:0] r;
    r = '0;
    if (st != 0) begin
      for (int i = 0; i < T; i++) begin
        int cx, cy;
        cx = v ? x : x + i;
        cy = v ? y + i : y;
        r[3+8*i +: 4] = 4'(cx);
        r[7+8*i +: 4] = 4'(9 - cy);
      end
    end
    return r;
  endfunction

  task automatic restart();
    mSt = 1; mx = 1; my = 1; mv = 1'b0;
  endtask

  task automatic modelStep();
    mErr = 1'b0;
    if (reset) begin
      mSt = 0; mx = 1; my = 1; mv = 1'b0;
    end else begin
      case (mSt)
        0: if (habilitar) restart();
        1: begin
          if (habilitar) restart();
          else if (btn_confirmar) mSt = 2;
          else if (btn_girar) begin if (fits(mx, my, ~mv)) mv = ~mv; end
          else if (btn_cima)  begin if (fits(mx, my + 1, mv)) my = my + 1; end
          else if (btn_baixo) begin if (fits(mx, my - 1, mv)) my = my - 1; end
          else if (btn_esq)   begin if (fits(mx - 1, my, mv)) mx = mx - 1; end
          else if (btn_dir)   begin if (fits(mx + 1, my, mv)) mx = mx + 1; end
        end
        2: begin
          if (habilitar) restart();
          else if (collides(mx, my, mv, mapaOcupado)) begin mErr = 1'b1; mSt = 1; end
          else mSt = 3;
        end
        default: if (habilitar) restart();
      endcase
    end
  endtask

  // Compare process: model expectations every cycle, plus optional literal pin.
  always @(negedge clk) begin
    logic [63:0] ev;
    ev = shipVec(mSt, mx, my, mv);
    nTests++;
    if (posicoesEmbarcacao !== ev) begin
      nFail++;
      $display("FAIL vector t=%0t: got %h expected %h", $time, posicoesEmbarcacao, ev);
    end
    nTests++;
    if (posicionada !== (mSt == 3)) begin
      nFail++;
      $display("FAIL posicionada t=%0t: got %b expected %b", $time, posicionada, mSt == 3);
    end
    nTests++;
    if (erro !== mErr) begin
      nFail++;
      $display("FAIL erro t=%0t: got %b expected %b", $time, erro, mErr);
    end
    nTests++;
    if (ocupado !== (mSt == 1 || mSt == 2)) begin
      nFail++;
      $display("FAIL ocupado t=%0t: got %b expected %b", $time, ocupado, (mSt == 1 || mSt == 2));
    end
    if (pinOn) begin
      nTests++;
      if ({posicoesEmbarcacao, posicionada, erro, ocupado} !== pinVal) begin
        nFail++;
        $display("FAIL pin_%s: got %h/%b%b%b expected %h/%b", pinName, posicoesEmbarcacao,
                 posicionada, erro, ocupado, pinVal[66:3], pinVal[2:0]);
      end
    end
  end

  // b = {habilitar, confirmar, girar, cima, baixo, esq, dir}
  task automatic cyc(input logic r, input logic [6:0] b);
    reset = r;
    {habilitar, btn_confirmar, btn_girar, btn_cima, btn_baixo, btn_esq, btn_dir} = b;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    #1;
    $display("[TB] t=%0t rst=%b cmd=%b map=%h vec=%h pos=%b err=%b ocu=%b", $time, r, b,
             mapaOcupado, posicoesEmbarcacao, posicionada, erro, ocupado);
  endtask

  task automatic pinCyc(input logic r, input logic [6:0] b, input string nm,
                        input logic [63:0] v, input logic [2:0] f);
    pinName = nm;
    pinVal  = {v, f};
    pinOn   = 1'b1;
    cyc(r, b);
    pinOn   = 1'b0;
  endtask

  localparam logic [6:0] HAB = 7'b1000000, CONF = 7'b0100000, GIR = 7'b0010000;
  localparam logic [6:0] CIMA = 7'b0001000, ESQ = 7'b0000010, DIR = 7'b0000001, NADA = 7'b0;

  initial begin
    logic [63:0] vIni, vDir3, vVert, vY5, vY2;
    vIni  = 64'h0000_0085_8483_8281 << 3;
    vDir3 = 64'h0000_0088_8786_8584 << 3;
    vVert = 64'h0000_0044_5464_7484 << 3;
    vY5   = 64'h0000_0045_4443_4241 << 3;
    vY2   = 64'h0000_0075_7473_7271 << 3;

    cyc(1'b1, NADA);
    pinCyc(1'b1, HAB, "reset", 64'h0, 3'b000);
    pinCyc(1'b0, HAB, "start", vIni, 3'b001);
    cyc(1'b0, DIR);
    cyc(1'b0, DIR);
    pinCyc(1'b0, DIR, "dir3", vDir3, 3'b001);
    pinCyc(1'b0, DIR, "dir4_ignored", vDir3, 3'b001);
    pinCyc(1'b0, GIR, "rotate", vVert, 3'b001);
    cyc(1'b0, HAB);
    for (int i = 0; i < 4; i++) cyc(1'b0, CIMA);
    pinCyc(1'b0, GIR, "rotate_ignored", vY5, 3'b001);
    cyc(1'b0, HAB);
    mapaOcupado = 64'h4;
    pinCyc(1'b0, CONF, "validating", vIni, 3'b001);
    pinCyc(1'b0, NADA, "erro_pulse", vIni, 3'b011);
    pinCyc(1'b0, NADA, "erro_gone", vIni, 3'b001);
    mapaOcupado = '0;
    cyc(1'b0, CONF);
    pinCyc(1'b0, NADA, "fixed", vIni, 3'b100);
    pinCyc(1'b0, DIR, "fixed_frozen", vIni, 3'b100);
    cyc(1'b0, HAB);
    pinCyc(1'b0, CONF | DIR, "conf_over_dir", vIni, 3'b001);
    cyc(1'b0, NADA);
    cyc(1'b0, HAB);
    pinCyc(1'b0, CIMA | ESQ, "cima_over_esq", vY2, 3'b001);
    mapaOcupado = 64'h4;
    cyc(1'b0, HAB);
    cyc(1'b0, CONF);
    pinCyc(1'b1, NADA, "reset_in_validating", 64'h0, 3'b000);
    cyc(1'b0, NADA);

    for (int n = 0; n < 4000; n++) begin
      logic [6:0] b;
      if (n % 50 == 0)
        mapaOcupado = ($urandom_range(0, 3) == 0) ? 64'h0 :
                      ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      b[6] = ($urandom_range(0, 39) == 0);
      b[5] = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 199) == 0, b);
    end

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
